display_mux_7seg: RTL



---
 rtl/display_mux_7seg.sv | 132 +++++++++++++
 1 files changed

// File: rtl/display_mux_7seg.sv
// Multiplexed N-digit 7-segment driver: latched digit codes scanned onto a shared
// segment bus with per-digit enables, hex/decimal decode and leading-zero blanking.
module display_mux_7seg #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] entrada,
    input  logic                    carregar,
    input  logic [NUM_DIGITS-1:0]   pontos,
    input  logic                    modo_hex,
    input  logic                    apagar_zeros,
    output logic [6:0]              segmentos,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodos
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL = 1'(ACTIVE_LOW != 0);
    localparam logic [6:0] SEG_OFF = {7{POL}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{POL}};

    logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
    logic [NUM_DIGITS-1:0]   pts_q, pts_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic [3:0]              code_s;
    logic                    pt_s;
    logic                    supp_s;
    logic                    zero_run_s;
    logic [6:0]              lit_s;
    logic [NUM_DIGITS-1:0]   an_lit_s;

    // gfedcba lit pattern; letters only exist in hex mode
    function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex);
        case (code)
            4'h0:    seg_decode = 7'h3F;
            4'h1:    seg_decode = 7'h06;
            4'h2:    seg_decode = 7'h5B;
            4'h3:    seg_decode = 7'h4F;
            4'h4:    seg_decode = 7'h66;
            4'h5:    seg_decode = 7'h6D;
            4'h6:    seg_decode = 7'h7D;
            4'h7:    seg_decode = 7'h07;
            4'h8:    seg_decode = 7'h7F;
            4'h9:    seg_decode = 7'h6F;
            4'hA:    seg_decode = hex ? 7'h77 : 7'h00;
            4'hB:    seg_decode = hex ? 7'h7C : 7'h00;
            4'hC:    seg_decode = hex ? 7'h39 : 7'h00;
            4'hD:    seg_decode = hex ? 7'h5E : 7'h00;
            4'hE:    seg_decode = hex ? 7'h79 : 7'h00;
            4'hF:    seg_decode = hex ? 7'h71 : 7'h00;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    // Shadow capture and scan counters
    always_comb begin
        dig_d   = carregar ? entrada : dig_q;
        pts_d   = carregar ? pontos  : pts_q;
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // Select current digit; zero_run tracks "this digit and all above are zero"
    always_comb begin
        code_s     = 4'h0;
        pt_s       = 1'b0;
        supp_s     = 1'b0;
        zero_run_s = 1'b1;
        an_lit_s   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_s  = zero_run_s && (dig_q[4*i +: 4] == 4'h0);
            code_s      = (idx_q == IW'(i)) ? dig_q[4*i +: 4] : code_s;
            pt_s        = (idx_q == IW'(i)) ? pts_q[i] : pt_s;
            supp_s      = (idx_q == IW'(i)) ? (apagar_zeros && zero_run_s && (i > 0)) : supp_s;
            an_lit_s[i] = (idx_q == IW'(i)) && (presc_q >= PW'(BLANK_CYCLES));
        end
        lit_s = supp_s ? 7'h00 : seg_decode(code_s, modo_hex);
    end

    // Apply output polarity ahead of the pin registers
    always_comb begin
        seg_d = lit_s ^ SEG_OFF;
        dp_d  = pt_s ^ POL;
        an_d  = an_lit_s ^ AN_OFF;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_q   <= '0;
            pts_q   <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_OFF;
            dp_q    <= POL;
            an_q    <= AN_OFF;
        end else begin
            dig_q   <= dig_d;
            pts_q   <= pts_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign segmentos = seg_q;
    assign dp        = dp_q;
    assign anodos    = an_q;

endmodule
